// File: rtl/thread_fetch_sched_pkg.sv
// Shared parameters and helpers for the 4-thread fetch scheduler.
// Build option: THREAD_SKIP_IDLE_EN (skip idle threads instead of strict barrel).
package thread_fetch_sched_pkg;

  localparam int NUM_THREADS      = 4;
  localparam int TID_W            = 2;
  localparam int PC_W             = 9;
  localparam int THREAD_PC_STRIDE = 128;

  localparam logic [NUM_THREADS-1:0] ALL_IDLE = {NUM_THREADS{1'b0}};

  // Reset PC of thread t, truncated to the imem word-address width.
  function automatic logic [PC_W-1:0] reset_pc(input int t);
    return PC_W'(t * THREAD_PC_STRIDE);
  endfunction

endpackage

// File: rtl/thread_fetch_sched_rr_next4.sv
// Rotate-priority picker: first set mask bit after last_tid, wrapping.
// Mask all-ones degenerates to last_tid+1.
module rr_next4
  import thread_fetch_sched_pkg::*;
(
  input  logic [TID_W-1:0]       i_last_tid,
  input  logic [NUM_THREADS-1:0] i_mask,
  output logic [TID_W-1:0]       o_next_tid,
  output logic                   o_any_hit
);

  // Scan farthest-first so the nearest candidate overrides.
  always_comb begin
    o_next_tid = i_last_tid + 1'b1;
    o_any_hit  = (i_mask != ALL_IDLE);
    for (int k = NUM_THREADS; k >= 1; k--) begin
      if (i_mask[i_last_tid + TID_W'(k)]) begin
        o_next_tid = i_last_tid + TID_W'(k);
      end
    end
  end

endmodule

// File: rtl/thread_fetch_sched.sv
// Round-robin thread scheduler and per-thread PC file.
// Build option: THREAD_SKIP_IDLE_EN (skip idle threads instead of strict barrel).
module thread_fetch_sched
  import thread_fetch_sched_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [NUM_THREADS-1:0] i_thread_active,
  input  logic                   i_br_valid,
  input  logic [TID_W-1:0]       i_br_tid,
  input  logic [PC_W-1:0]        i_br_target,
  output logic                   o_fetch_valid,
  output logic [TID_W-1:0]       o_fetch_tid,
  output logic [PC_W-1:0]        o_fetch_pc
);

  logic [PC_W-1:0]        r_pc [NUM_THREADS];
  logic [TID_W-1:0]       r_last_tid;
  logic                   r_fetch_valid;
  logic [TID_W-1:0]       r_fetch_tid;
  logic [PC_W-1:0]        r_fetch_pc;

  logic [NUM_THREADS-1:0] w_mask;
  logic [TID_W-1:0]       w_sel;
  logic                   w_hit;
  logic                   w_issue;

  // Candidate mask: active threads, or every slot in strict barrel mode.
  always_comb begin
`ifdef THREAD_SKIP_IDLE_EN
    w_mask = i_thread_active;
`else
    w_mask = {NUM_THREADS{1'b1}};
`endif
  end

  rr_next4 u_pick (
    .i_last_tid (r_last_tid),
    .i_mask     (w_mask),
    .o_next_tid (w_sel),
    .o_any_hit  (w_hit)
  );

  // A slot is real only if the picked thread is running.
  assign w_issue = w_hit & i_thread_active[w_sel];

  // Issue registers and rotation pointer; a stall holds everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_tid    <= TID_W'(NUM_THREADS - 1);
      r_fetch_valid <= 1'b0;
      r_fetch_tid   <= '0;
      r_fetch_pc    <= '0;
    end else if (i_en) begin
      r_fetch_valid <= w_issue;
      if (w_hit) begin
        r_last_tid  <= w_sel;
        r_fetch_tid <= w_sel;
        r_fetch_pc  <= r_pc[w_sel];
      end
    end
  end

  // PC file: redirect beats the post-issue increment.
  always_ff @(posedge i_clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (i_reset) begin
        r_pc[t] <= reset_pc(t);
      end else if (i_br_valid && i_br_tid == TID_W'(t)) begin
        r_pc[t] <= i_br_target;
      end else if (i_en && w_issue && w_sel == TID_W'(t)) begin
        r_pc[t] <= r_pc[t] + 1'b1;
      end
    end
  end

  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_tid   = r_fetch_tid;
  assign o_fetch_pc    = r_fetch_pc;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Randomized bench with a behavioural scheduler model.
// Build option: THREAD_SKIP_IDLE_EN (skip idle threads instead of strict barrel).
module tb_thread_fetch_sched;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] thread_active;
  logic       br_valid;
  logic [1:0] br_tid;
  logic [8:0] br_target;
  logic       fetch_valid;
  logic [1:0] fetch_tid;
  logic [8:0] fetch_pc;

  int errors = 0;
  int checks = 0;

  int m_pc [4];
  int m_last;
  int e_valid, e_tid, e_pc;
  bit e_pc_known;

  thread_fetch_sched dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_en            (en),
    .i_thread_active (thread_active),
    .i_br_valid      (br_valid),
    .i_br_tid        (br_tid),
    .i_br_target     (br_target),
    .o_fetch_valid   (fetch_valid),
    .o_fetch_tid     (fetch_tid),
    .o_fetch_pc      (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: apply the scheduling rules to the inputs seen at this edge.
  task automatic model_edge();
    int sel;
    bit found;
    if (reset) begin
      for (int t = 0; t < 4; t++) m_pc[t] = (t * 128) % 512;
      m_last = 3;
      e_valid = 0; e_tid = 0; e_pc = 0;
      e_pc_known = 1;
      return;
    end
    sel = -1;
    found = 0;
    if (en) begin
`ifdef THREAD_SKIP_IDLE_EN
      for (int k = 1; k <= 4; k++) begin
        if (!found && thread_active[(m_last + k) % 4]) begin
          sel = (m_last + k) % 4;
          found = 1;
        end
      end
      e_valid = found;
      if (found) begin
        e_tid = sel; e_pc = m_pc[sel]; m_last = sel;
        e_pc_known = 1;
      end
`else
      sel = (m_last + 1) % 4;
      m_last = sel;
      e_tid = sel;
      found = thread_active[sel];
      e_valid = found;
      e_pc = m_pc[sel];
      e_pc_known = found;
`endif
      if (found) m_pc[sel] = (m_pc[sel] + 1) % 512;
    end
    if (br_valid) m_pc[br_tid] = br_target;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", fetch_valid, e_valid);
    chk("tid", fetch_tid, e_tid);
    if (e_pc_known) chk("pc", fetch_pc, e_pc);
  endtask

  task automatic idle_inputs();
    reset = 0; en = 1; thread_active = 4'hF;
    br_valid = 0; br_tid = 0; br_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  int exp_tid1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_pc1  [8] = '{0, 128, 256, 384, 1, 129, 257, 385};

  initial begin
    idle_inputs();
    e_pc_known = 0;
    e_valid = 0; e_tid = 0; e_pc = 0;
    m_last = 3;
    for (int t = 0; t < 4; t++) m_pc[t] = 0;

    // 1: reset then plain rotation, also against fixed constants
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s1_tid", fetch_tid, exp_tid1[i]);
      chk("s1_pc", fetch_pc, exp_pc1[i]);
    end

    // 2: threads 0 and 2 only
    do_reset();
    thread_active = 4'b0101;
    for (int i = 0; i < 8; i++) step();
    thread_active = 4'hF;
    for (int i = 0; i < 4; i++) step();

    // 3: redirect thread 1 in the cycle it is selected
    do_reset();
    step();
    br_valid = 1; br_tid = 1; br_target = 9'h020;
    step();
    br_valid = 0;
    for (int i = 0; i < 9; i++) step();

    // 4: stall with redirect to thread 2 inside it
    en = 0;
    step();
    br_valid = 1; br_tid = 2; br_target = 9'h0AB;
    step();
    br_valid = 0;
    step();
    en = 1;
    for (int i = 0; i < 6; i++) step();

    // 5: wrap of thread 3
    br_valid = 1; br_tid = 3; br_target = 9'h1FF;
    step();
    br_valid = 0;
    for (int i = 0; i < 9; i++) step();

    // 6: mid-run reset, then all idle
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) step();
    thread_active = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    thread_active = 4'b1000;
    for (int i = 0; i < 3; i++) step();
    thread_active = 4'hF;
    for (int i = 0; i < 4; i++) step();

    // random mix
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      en            = ($urandom_range(0, 3) != 0);
      thread_active = 4'($urandom_range(0, 15));
      br_valid      = ($urandom_range(0, 3) == 0);
      br_tid        = 2'($urandom_range(0, 3));
      br_target     = 9'($urandom_range(0, 511));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
